// File: rtl/riscv_pipeline_cpu.sv
// rtl/riscv_pipeline_cpu.sv - 5-stage RV32I/M subset pipeline with internal memories
// ID-stage branch resolution, EX-stage forwarding and single-cycle load-use stall.

module pc_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i)        pc_o <= '0;
        else if (!hold_i) pc_o <= pc_i;
    end
endmodule

module instr_mem (
    input  logic [7:0]  addr_i,
    output logic [31:0] instr_o
);
    logic [31:0] memory [0:255];
    assign instr_o = memory[addr_i];
endmodule

module reg_file (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i && rd_i != 5'd0) regs[rd_i] <= wdata_i;
    end

    // Same-cycle writeback is visible to the ID read (write-before-read)
    assign rs1_data_o = (rs1_i == 5'd0) ? '0 : (we_i && rd_i == rs1_i) ? wdata_i : regs[rs1_i];
    assign rs2_data_o = (rs2_i == 5'd0) ? '0 : (we_i && rd_i == rs2_i) ? wdata_i : regs[rs2_i];
endmodule

module data_mem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [31:0] memory [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i) memory[addr_i] <= wdata_i;
    end

    assign rdata_o = re_i ? memory[addr_i] : '0;
endmodule

module control (
    input  logic [6:0] opcode_i,
    output logic [6:0] ctrl_o,
    output logic       Branch_o
);
    // ctrl_o = {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}
    always_comb begin
        ctrl_o   = 7'b0000000;
        Branch_o = 1'b0;
        case (opcode_i)
            7'b0110011: ctrl_o = 7'b1000100;
            7'b0010011: ctrl_o = 7'b1000111;
            7'b0000011: ctrl_o = 7'b1110001;
            7'b0100011: ctrl_o = 7'b0001001;
            7'b1100011: begin
                ctrl_o   = 7'b0000010;
                Branch_o = 1'b1;
            end
            default: ctrl_o = 7'b0000000;
        endcase
    end
endmodule

module hazard_unit (
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    output logic       Stall_o
);
    assign Stall_o = idex_mem_read_i && idex_rd_i != 5'd0 &&
                     (idex_rd_i == rs1_i || idex_rd_i == rs2_i);
endmodule

module pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         hold_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i)       q_o <= '0;
        else if (hold_i) q_o <= q_o;
        else if (clr_i)  q_o <= '0;
        else             q_o <= d_i;
    end
endmodule

module riscv_pipeline_cpu (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    logic [31:0]  pc, pc_next, instr, counter;
    logic         Flush, stall, freeze, branch;
    logic [63:0]  ifid_q;
    logic [127:0] idex_q;
    logic [72:0]  exmem_q;
    logic [70:0]  memwb_q;

    logic [31:0] ifid_pc, ifid_instr, rs1_data, rs2_data, imm;
    logic [6:0]  ctrl, ex_ctrl;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, fwd_a, fwd_b, alu_b, alu_y;
    logic [9:0]  ex_funct;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic signed [31:0] sra_y;
    logic [3:0]  mem_ctrl;
    logic [31:0] mem_alu, mem_wdata, mem_rdata, wb_rdata, wb_alu, wb_data;
    logic        wb_reg_write, wb_mem_to_reg;

    assign freeze  = stall || !start_i;
    assign Flush   = branch && (rs1_data == rs2_data) && !stall && start_i;
    assign pc_next = Flush ? ifid_pc + {imm[30:0], 1'b0} : pc + 32'd4;

    pc_reg PC (.clk_i(clk_i), .rst_i(rst_i), .hold_i(freeze), .pc_i(pc_next), .pc_o(pc));
    instr_mem Instruction_Memory (.addr_i(pc[9:2]), .instr_o(instr));

    pipe_reg #(.W(64)) IFID (.clk_i(clk_i), .rst_i(rst_i), .hold_i(freeze), .clr_i(Flush),
                             .d_i({pc, instr}), .q_o(ifid_q));
    assign {ifid_pc, ifid_instr} = ifid_q;

    control Control (.opcode_i(ifid_instr[6:0]), .ctrl_o(ctrl), .Branch_o(branch));

    reg_file Registers (.clk_i(clk_i), .we_i(wb_reg_write), .rs1_i(ifid_instr[19:15]),
                        .rs2_i(ifid_instr[24:20]), .rd_i(wb_rd), .wdata_i(wb_data),
                        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data));

    hazard_unit Hazard_Detection_Unit (.idex_mem_read_i(ex_ctrl[4]), .idex_rd_i(ex_rd),
                                       .rs1_i(ifid_instr[19:15]), .rs2_i(ifid_instr[24:20]),
                                       .Stall_o(stall));

    always_comb begin
        case (ifid_instr[6:0])
            7'b0010011, 7'b0000011: imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            7'b0100011: imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            7'b1100011: imm = {{20{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                               ifid_instr[30:25], ifid_instr[11:8]};
            default:    imm = '0;
        endcase
    end

    pipe_reg #(.W(128)) IDEX (.clk_i(clk_i), .rst_i(rst_i), .hold_i(1'b0), .clr_i(freeze),
                              .d_i({ctrl, rs1_data, rs2_data, imm, ifid_instr[31:25],
                                    ifid_instr[14:12], ifid_instr[19:15], ifid_instr[24:20],
                                    ifid_instr[11:7]}),
                              .q_o(idex_q));
    assign {ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm, ex_funct, ex_rs1, ex_rs2, ex_rd} = idex_q;

    always_comb begin
        fwd_a = ex_rs1_data;
        if (mem_ctrl[3] && mem_rd != 5'd0 && mem_rd == ex_rs1)       fwd_a = mem_alu;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)   fwd_a = wb_data;
        fwd_b = ex_rs2_data;
        if (mem_ctrl[3] && mem_rd != 5'd0 && mem_rd == ex_rs2)       fwd_b = mem_alu;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)   fwd_b = wb_data;
    end

    assign alu_b = ex_ctrl[0] ? ex_imm : fwd_b;
    assign sra_y = $signed(fwd_a) >>> alu_b[4:0];

    always_comb begin
        alu_y = '0;
        case (ex_ctrl[2:1])
            2'b00: alu_y = fwd_a + alu_b;
            2'b01: alu_y = fwd_a - alu_b;
            2'b10: begin
                case (ex_funct)
                    10'b0000000_111: alu_y = fwd_a & alu_b;
                    10'b0000000_100: alu_y = fwd_a ^ alu_b;
                    10'b0000000_001: alu_y = fwd_a << alu_b[4:0];
                    10'b0000000_000: alu_y = fwd_a + alu_b;
                    10'b0100000_000: alu_y = fwd_a - alu_b;
                    10'b0000001_000: alu_y = fwd_a * alu_b;
                    default:         alu_y = '0;
                endcase
            end
            default: alu_y = (ex_funct[2:0] == 3'b101) ? sra_y : fwd_a + alu_b;
        endcase
    end

    pipe_reg #(.W(73)) EXMEM (.clk_i(clk_i), .rst_i(rst_i), .hold_i(1'b0), .clr_i(1'b0),
                              .d_i({ex_ctrl[6:3], alu_y, fwd_b, ex_rd}), .q_o(exmem_q));
    assign {mem_ctrl, mem_alu, mem_wdata, mem_rd} = exmem_q;

    data_mem Data_Memory (.clk_i(clk_i), .we_i(mem_ctrl[0]), .re_i(mem_ctrl[1]),
                          .addr_i(mem_alu[6:2]), .wdata_i(mem_wdata), .rdata_o(mem_rdata));

    pipe_reg #(.W(71)) MEMWB (.clk_i(clk_i), .rst_i(rst_i), .hold_i(1'b0), .clr_i(1'b0),
                              .d_i({mem_ctrl[3:2], mem_rdata, mem_alu, mem_rd}), .q_o(memwb_q));
    assign {wb_reg_write, wb_mem_to_reg, wb_rdata, wb_alu, wb_rd} = memwb_q;
    assign wb_data = wb_mem_to_reg ? wb_rdata : wb_alu;

    always_ff @(posedge clk_i) begin
        if (rst_i)        counter <= '0;
        else if (start_i) counter <= counter + 32'd1;
    end
endmodule

// File: tb/tb_riscv_pipeline_cpu.sv
// tb/tb_riscv_pipeline_cpu.sv - randomized and directed checks against an ISA-level model
module tb_riscv_pipeline_cpu;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    int checks = 0;
    int errors = 0;
    int n_stall, n_flush, exp_stall;
    logic [31:0] prog [$];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [32];

    riscv_pipeline_cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        logic [31:0] a, b, c, d, e;
        a = f7; b = f3; c = rd; d = rs1; e = rs2;
        return {a[6:0], e[4:0], d[4:0], b[2:0], c[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int f3, input int rd, input int rs1, input int imm);
        logic [31:0] o, b, c, d, m;
        o = op; b = f3; c = rd; d = rs1; m = imm;
        return {m[11:0], d[4:0], b[2:0], c[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(7'b0010011, 0, rd, rs1, imm);
    endfunction

    function automatic logic [31:0] enc_sw(input int rs2, input int rs1, input int imm);
        logic [31:0] d, e, m;
        d = rs1; e = rs2; m = imm;
        return {m[11:5], e[4:0], d[4:0], 3'b010, m[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_beq(input int rs1, input int rs2, input int off);
        logic [31:0] d, e, m;
        d = rs1; e = rs2; m = off;
        return {m[12], m[10:5], e[4:0], d[4:0], 3'b000, m[4:1], m[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_instr();
        int rd, rs1, rs2, sel;
        rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
        sel = $urandom_range(0, 9);
        case (sel)
            0: return enc_r(7'b0000000, 3'b000, rd, rs1, rs2);
            1: return enc_r(7'b0100000, 3'b000, rd, rs1, rs2);
            2: return enc_r(7'b0000000, 3'b111, rd, rs1, rs2);
            3: return enc_r(7'b0000000, 3'b100, rd, rs1, rs2);
            4: return enc_r(7'b0000000, 3'b001, rd, rs1, rs2);
            5: return enc_r(7'b0000001, 3'b000, rd, rs1, rs2);
            6: return addi(rd, rs1, $urandom_range(0, 4095));
            7: return enc_i(7'b0010011, 3'b101, rd, rs1, 32'h400 | $urandom_range(0, 31));
            8: return enc_i(7'b0000011, 3'b010, rd, 0, 4 * $urandom_range(0, 7));
            default: return enc_sw(rs2, 0, 4 * $urandom_range(0, 7));
        endcase
    endfunction

    // Sequential ISA interpreter: one instruction at a time, no pipeline notion
    task automatic model_exec(input logic [31:0] ins);
        logic [31:0] a, b, res, imm_i, imm_s, addr;
        logic wr;
        a = m_regs[ins[19:15]];
        b = m_regs[ins[24:20]];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        res = 32'h0;
        wr = 1'b1;
        case (ins[6:0])
            7'b0110011: begin
                case ({ins[31:25], ins[14:12]})
                    10'b0000000111: res = a & b;
                    10'b0000000100: res = a ^ b;
                    10'b0000000001: res = a << b[4:0];
                    10'b0000000000: res = a + b;
                    10'b0100000000: res = a - b;
                    10'b0000001000: res = a * b;
                    default:        res = 32'h0;
                endcase
            end
            7'b0010011: begin
                if (ins[14:12] == 3'b101) res = $signed(a) >>> ins[24:20];
                else                      res = a + imm_i;
            end
            7'b0000011: begin
                addr = a + imm_i;
                res = m_mem[addr[6:2]];
            end
            7'b0100011: begin
                addr = a + imm_s;
                m_mem[addr[6:2]] = b;
                wr = 1'b0;
            end
            default: wr = 1'b0;
        endcase
        if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    endtask

    task automatic model_run();
        logic [31:0] cur, nxt;
        exp_stall = 0;
        for (int i = 0; i < prog.size(); i++) begin
            cur = prog[i];
            nxt = (i + 1 < prog.size()) ? prog[i + 1] : 32'h0;
            model_exec(cur);
            if (cur[6:0] == 7'b0000011 && cur[11:7] != 5'd0 &&
                (cur[11:7] == nxt[19:15] || cur[11:7] == nxt[24:20]))
                exp_stall++;
        end
    endtask

    task automatic load_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < 256; i++)
            dut.Instruction_Memory.memory[i] = (i < prog.size()) ? prog[i] : 32'h0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic run(input int cycles);
        n_stall = 0;
        n_flush = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            if (dut.Hazard_Detection_Unit.Stall_o) n_stall++;
            if (dut.Flush) n_flush++;
        end
    endtask

    task automatic check_reg(input string name, input int r, input logic [31:0] exp);
        checks++;
        if (dut.Registers.regs[r] !== exp) begin
            errors++;
            $display("FAIL %s x%0d got %h expected %h", name, r, dut.Registers.regs[r], exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        prog = {};
        load_reset();
        checks++;
        if (dut.PC.pc_o !== 32'h0 || dut.counter !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc_counter got pc=%h cnt=%h expected 0/0", dut.PC.pc_o, dut.counter);
        end
        checks++;
        if (dut.IFID.q_o !== '0 || dut.IDEX.q_o !== '0 || dut.EXMEM.q_o !== '0 || dut.MEMWB.q_o !== '0) begin
            errors++;
            $display("FAIL reset_pipe got ifid=%h memwb=%h expected 0", dut.IFID.q_o, dut.MEMWB.q_o);
        end
        @(negedge clk_i);
        checks++;
        if (dut.PC.pc_o !== 32'h0 || dut.counter !== 32'h0) begin
            errors++;
            $display("FAIL start_low_hold got pc=%h cnt=%h expected 0/0", dut.PC.pc_o, dut.counter);
        end
        start_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            checks++;
            if (dut.PC.pc_o !== 32'(4 * k) || dut.counter !== 32'(k)) begin
                errors++;
                $display("FAIL pc_step%0d got pc=%h cnt=%h expected %h/%h", k, dut.PC.pc_o, dut.counter, 4 * k, k);
            end
        end
    endtask

    task automatic test_forwarding();
        prog = {addi(1, 0, 5), enc_r(0, 0, 2, 1, 1), enc_r(7'b0100000, 0, 3, 2, 1)};
        load_reset(); start_i = 1'b1;
        run(prog.size() + 10);
        check_reg("fwd_x1", 1, 32'd5);
        check_reg("fwd_x2", 2, 32'd10);
        check_reg("fwd_x3", 3, 32'd5);
        check_int("fwd_stalls", n_stall, 0);
    endtask

    task automatic test_load_use();
        prog = {addi(10, 0, 5), enc_sw(10, 0, 0), enc_i(7'b0000011, 3'b010, 4, 0, 0), enc_r(0, 0, 5, 4, 4)};
        load_reset(); start_i = 1'b1;
        run(prog.size() + 10);
        check_reg("lu_x4", 4, 32'd5);
        check_reg("lu_x5", 5, 32'd10);
        check_int("lu_stalls", n_stall, 1);
    endtask

    task automatic test_store_ops();
        prog = {addi(28, 0, 56), addi(24, 0, -24), enc_sw(28, 0, 4),
                enc_i(7'b0010011, 3'b101, 6, 24, 32'h402), enc_r(7'b0000001, 0, 7, 24, 28)};
        load_reset(); start_i = 1'b1;
        run(prog.size() + 10);
        checks++;
        if (dut.Data_Memory.memory[1] !== 32'd56) begin
            errors++;
            $display("FAIL sw_mem1 got %h expected %h", dut.Data_Memory.memory[1], 32'd56);
        end
        check_reg("srai_x6", 6, 32'hFFFF_FFFA);
        check_reg("mul_x7", 7, 32'hFFFF_FAC0);
    endtask

    task automatic test_branch();
        logic seen;
        seen = 1'b0;
        n_flush = 0;
        prog = {addi(8, 0, 0), enc_beq(0, 0, 8), addi(8, 0, 1), addi(11, 0, 9)};
        load_reset(); start_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_i);
            if (seen) begin
                checks++;
                if (dut.PC.pc_o !== 32'd12) begin
                    errors++;
                    $display("FAIL br_target got %h expected %h", dut.PC.pc_o, 32'd12);
                end
                seen = 1'b0;
            end
            if (dut.Flush) begin
                n_flush++;
                seen = 1'b1;
            end
        end
        check_int("br_flushes", n_flush, 1);
        check_reg("br_x8_skipped", 8, 32'd0);
        check_reg("br_x11", 11, 32'd9);
    endtask

    task automatic test_x0();
        prog = {addi(0, 0, 7), addi(9, 0, 3)};
        load_reset(); start_i = 1'b1;
        run(prog.size() + 10);
        check_reg("x0_write", 0, 32'd0);
        check_reg("x0_read_x9", 9, 32'd3);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            prog = {};
            for (int r = 1; r < 8; r++) prog.push_back(addi(r, 0, $urandom_range(0, 4095)));
            for (int k = 0; k < 8; k++) prog.push_back(enc_sw(k, 0, 4 * k));
            for (int k = 0; k < 30; k++) prog.push_back(rand_instr());
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'h0;
                m_mem[r] = 32'h0;
            end
            model_run();
            load_reset(); start_i = 1'b1;
            run(prog.size() + 20);
            for (int r = 1; r < 8; r++) check_reg("rand_reg", r, m_regs[r]);
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (dut.Data_Memory.memory[k] !== m_mem[k]) begin
                    errors++;
                    $display("FAIL rand_mem[%0d] got %h expected %h", k, dut.Data_Memory.memory[k], m_mem[k]);
                end
            end
            check_int("rand_stalls", n_stall, exp_stall);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_store_ops();
        test_branch();
        test_x0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
